// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe
//   Pipelined binary 2:1 mux tree. N = 2**LOG2N inputs of WIDTH bits are
//   reduced level by level; every level is followed by a register stage, so
//   latency is LOG2N cycles regardless of the configured group depth.
//   With active depth k, output lane g carries input g*2**k + sel[k-1:0];
//   lanes beyond N/2**k are forced to zero. Levels at or above k pass data
//   through (still registered).
//
// Ports
//   UserCLK   : clock, all state on rising edge
//   resetn    : asynchronous active-low reset
//   in_data   : N*WIDTH, input i at [i*WIDTH +: WIDTH]
//   in_sel    : LOG2N select, bit j steers tree level j
//   in_valid / in_ready   : input handshake
//   out_data  : (N/2)*WIDTH, lane g at [g*WIDTH +: WIDTH]
//   out_valid / out_ready : output handshake
//   cfg_mode  : requested group depth (0 -> 1, >LOG2N -> LOG2N)
//   cfg_load  : single-cycle strobe capturing cfg_mode as pending depth
//   cfg_busy  : depth change pending; input blocked until pipeline drains
//   out_par   : (only with MUX_TREE_PIPE_PARITY_EN) per-lane XOR of out_data
//
// Build option
//   `define MUX_TREE_PIPE_PARITY_EN adds the out_par output.

module mux_tree_pipe #(
  parameter int WIDTH = 4,
  parameter int LOG2N = 3
) (
  input  logic                             UserCLK,
  input  logic                             resetn,
  input  logic [(WIDTH<<LOG2N)-1:0]        in_data,
  input  logic [LOG2N-1:0]                 in_sel,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [(WIDTH<<(LOG2N-1))-1:0]    out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic [2:0]                       cfg_mode,
  input  logic                             cfg_load,
  output logic                             cfg_busy
`ifdef MUX_TREE_PIPE_PARITY_EN
  ,
  output logic [(1<<(LOG2N-1))-1:0]        out_par
`endif
);

  localparam int N     = 1 << LOG2N;
  localparam int LANES = N / 2;
  localparam int HW    = LANES * WIDTH;
  localparam int FW    = N * WIDTH;
  localparam logic [2:0] DMAX = 3'(LOG2N);

  logic [HW-1:0]    data_q [LOG2N];
  logic [HW-1:0]    data_d [LOG2N];
  logic [LOG2N-1:0] sel_q  [LOG2N];
  logic [LOG2N-1:0] vld_q;

  logic [2:0] act_q;
  logic [2:0] pend_q;
  logic       busy_q;

  logic adv;
  logic xfer;

  logic [FW-1:0]    src;
  logic [LOG2N-1:0] sel_src;

  function automatic logic [2:0] clamp_depth(input logic [2:0] m);
    if (m == 3'd0)  return 3'd1;
    if (m > DMAX)   return DMAX;
    return m;
  endfunction

  assign adv      = !vld_q[LOG2N-1] || out_ready;
  assign in_ready = adv && !busy_q;
  assign xfer     = in_valid && in_ready;

  // Every level sees a full N-lane view of its source (upper half zero for
  // levels >= 1) so mux levels and pass-through levels share one lane map.
  always_comb begin
    src     = '0;
    sel_src = '0;
    for (int unsigned j = 0; j < LOG2N; j++) begin
      src = '0;
      if (j == 0) begin
        src     = in_data;
        sel_src = in_sel;
      end else begin
        src[HW-1:0] = data_q[j-1];
        sel_src     = sel_q[j-1];
      end
      data_d[j] = '0;
      for (int unsigned m = 0; m < LANES; m++) begin
        if (j < {29'd0, act_q}) begin
          if (m < (N >> (j + 1))) begin
            data_d[j][m*WIDTH +: WIDTH] = sel_src[j] ? src[(2*m+1)*WIDTH +: WIDTH]
                                                     : src[(2*m)*WIDTH +: WIDTH];
          end
        end else begin
          data_d[j][m*WIDTH +: WIDTH] = src[m*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      for (int unsigned j = 0; j < LOG2N; j++) begin
        data_q[j] <= '0;
        sel_q[j]  <= '0;
      end
    end else if (adv) begin
      vld_q[0]  <= xfer;
      data_q[0] <= data_d[0];
      sel_q[0]  <= in_sel;
      for (int unsigned j = 1; j < LOG2N; j++) begin
        vld_q[j]  <= vld_q[j-1];
        data_q[j] <= data_d[j];
        sel_q[j]  <= sel_q[j-1];
      end
    end
  end

  // Depth only switches with the pipeline empty, so a single active-depth
  // register is valid for every level. A load arriving on the drain edge
  // wins; the still-empty pipeline lets it apply on the following edge.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      pend_q <= DMAX;
      act_q  <= DMAX;
    end else if (cfg_load) begin
      pend_q <= clamp_depth(cfg_mode);
      busy_q <= 1'b1;
    end else if (busy_q && (vld_q == '0)) begin
      act_q  <= pend_q;
      busy_q <= 1'b0;
    end
  end

  assign out_data  = data_q[LOG2N-1];
  assign out_valid = vld_q[LOG2N-1];
  assign cfg_busy  = busy_q;

`ifdef MUX_TREE_PIPE_PARITY_EN
  logic [LANES-1:0] par_q;

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      par_q <= '0;
    end else if (adv) begin
      for (int unsigned g = 0; g < LANES; g++) begin
        par_q[g] <= ^data_d[LOG2N-1][g*WIDTH +: WIDTH];
      end
    end
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Testbench for mux_tree_pipe (WIDTH=4, LOG2N=3): randomized traffic checked
// against a lane-formula reference model and an in-order expectation queue.
module tb_mux_tree_pipe;
  localparam int WIDTH = 4;
  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int LANES = 4;

  logic        UserCLK = 1'b0;
  logic        resetn;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  cfg_mode;
  logic        cfg_load;
  logic        cfg_busy;
`ifdef MUX_TREE_PIPE_PARITY_EN
  logic [3:0]  out_par;
`endif

  int checks = 0;
  int errors = 0;
  int model_depth = LOG2N;

  mux_tree_pipe #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
    .UserCLK  (UserCLK),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cfg_mode (cfg_mode),
    .cfg_load (cfg_load),
    .cfg_busy (cfg_busy)
`ifdef MUX_TREE_PIPE_PARITY_EN
    ,
    .out_par  (out_par)
`endif
  );

  always #5 UserCLK = ~UserCLK;

  // Lane g of a group-depth-k tree selects input g*2^k + (sel mod 2^k).
  function automatic logic [15:0] model_out(input logic [31:0] d, input logic [2:0] s, input int k);
    logic [15:0] r;
    int grp;
    int idx;
    r   = '0;
    grp = 1 << k;
    for (int g = 0; g < LANES; g++) begin
      if (g < N / grp) begin
        idx = g * grp + (int'(s) % grp);
        r[g*4 +: 4] = 4'((d >> (idx * 4)) & 32'hF);
      end
    end
    return r;
  endfunction

  function automatic int clamp_model(input int m);
    if (m == 0) return 1;
    if (m > LOG2N) return LOG2N;
    return m;
  endfunction

`ifdef MUX_TREE_PIPE_PARITY_EN
  function automatic logic [3:0] model_par(input logic [15:0] v);
    logic [3:0] p;
    for (int g = 0; g < LANES; g++) p[g] = ^v[g*4 +: 4];
    return p;
  endfunction
`endif

  task automatic next_cycle();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0;
    out_ready = 1'b0; cfg_mode = '0; cfg_load = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy: got %b expected 0", cfg_busy); end
    @(posedge UserCLK); @(posedge UserCLK); #1;
    resetn = 1'b1;
    @(negedge UserCLK);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    model_depth = LOG2N;
    next_cycle();
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [2:0]  s;
    d = 32'h87654321; s = 3'd5;
    in_data = d; in_sel = s; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge UserCLK);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b expected 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge UserCLK);
      checks++; if (out_valid !== (c == 3)) begin errors++; $display("FAIL basic_valid_c%0d: got %b expected %b", c, out_valid, (c == 3)); end
      if (c == 3) begin
        checks++; if (out_data !== model_out(d, s, model_depth)) begin errors++; $display("FAIL basic_data: got %h expected %h", out_data, model_out(d, s, model_depth)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_depth_one();
    logic [31:0] d;
    logic [2:0]  s;
    cfg_mode = 3'd1; cfg_load = 1'b1;
    next_cycle();
    cfg_load = 1'b0;
    @(negedge UserCLK);
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL d1_busy_set: got %b expected 1", cfg_busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL d1_ready_blocked: got %b expected 0", in_ready); end
    next_cycle();
    @(negedge UserCLK);
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL d1_busy_clear: got %b expected 0", cfg_busy); end
    model_depth = clamp_model(1);
    next_cycle();
    d = 32'h87654321; s = 3'd1;
    in_data = d; in_sel = s; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge UserCLK);
      checks++; if (out_valid !== (c == 3)) begin errors++; $display("FAIL d1_valid_c%0d: got %b expected %b", c, out_valid, (c == 3)); end
      if (c == 3) begin
        checks++; if (out_data !== model_out(d, s, model_depth)) begin errors++; $display("FAIL d1_data: got %h expected %h", out_data, model_out(d, s, model_depth)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dv [10];
    logic [2:0]  sv [10];
    logic [15:0] q [$];
    logic [15:0] e;
    int sent, got;
    for (int i = 0; i < 10; i++) begin dv[i] = $urandom(); sv[i] = 3'($urandom_range(0, 7)); end
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < 10);
      if (sent < 10) begin in_data = dv[sent]; in_sel = sv[sent]; end
      @(negedge UserCLK);
      if (cyc >= 4 && cyc <= 6) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready_c%0d: got %b expected 0", cyc, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall_valid_c%0d: got %b expected 1", cyc, out_valid); end
        if (q.size() > 0) begin
          checks++; if (out_data !== q[0]) begin errors++; $display("FAIL b2b_stall_hold_c%0d: got %h expected %h", cyc, out_data, q[0]); end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_output: got %h expected none", out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== e) begin errors++; $display("FAIL b2b_data_%0d: got %h expected %h", got, out_data, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model_out(dv[sent], sv[sent], model_depth));
        sent++;
      end
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", got); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d expected 0", q.size()); end
  endtask

  task automatic test_cfg_inflight();
    logic [31:0] dv [3];
    logic [2:0]  sv [3];
    logic [15:0] q [$];
    logic [15:0] e;
    int acc [$];
    int n;
    logic done;
    logic exp_v;
    // restore full depth through an out-of-range request
    cfg_mode = 3'd7; cfg_load = 1'b1;
    next_cycle();
    cfg_load = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge UserCLK);
      if (!cfg_busy) done = 1'b1;
      next_cycle();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL cfg_clamp_drain: got busy expected idle"); end
    model_depth = clamp_model(7);

    for (int i = 0; i < 3; i++) begin dv[i] = $urandom(); sv[i] = 3'($urandom_range(0, 7)); end
    n = 0; out_ready = 1'b1;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      cfg_load = (cyc == 1);
      cfg_mode = 3'd2;
      in_valid = (n < 3);
      if (n < 3) begin in_data = dv[n]; in_sel = sv[n]; end
      @(negedge UserCLK);
      // B leaves at cycle 4, the empty pipeline is visible at 5, busy drops at 6
      checks++; if (cfg_busy !== (cyc >= 2 && cyc <= 5)) begin errors++; $display("FAIL cfg_busy_c%0d: got %b expected %b", cyc, cfg_busy, (cyc >= 2 && cyc <= 5)); end
      checks++; if (in_ready !== !(cyc >= 2 && cyc <= 5)) begin errors++; $display("FAIL cfg_ready_c%0d: got %b expected %b", cyc, in_ready, !(cyc >= 2 && cyc <= 5)); end
      exp_v = 1'b0;
      foreach (acc[i]) if (acc[i] + 3 == cyc) exp_v = 1'b1;
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL cfg_valid_c%0d: got %b expected %b", cyc, out_valid, exp_v); end
      if (out_valid && q.size() > 0) begin
        e = q.pop_front();
        checks++; if (out_data !== e) begin errors++; $display("FAIL cfg_data_c%0d: got %h expected %h", cyc, out_data, e); end
      end
      if (in_valid && in_ready) begin
        q.push_back(model_out(dv[n], sv[n], model_depth));
        acc.push_back(cyc);
        n++;
      end
      if (cyc == 5) model_depth = clamp_model(2);
      next_cycle();
    end
    in_valid = 1'b0; cfg_load = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL cfg_accepted: got %0d expected 3", n); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL cfg_leftover: got %0d expected 0", q.size()); end
  endtask

  task automatic test_cfg_zero();
    logic [31:0] d;
    logic [2:0]  s;
    logic done;
    cfg_mode = 3'd0; cfg_load = 1'b1;
    next_cycle();
    cfg_load = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge UserCLK);
      if (!cfg_busy) done = 1'b1;
      next_cycle();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_drain: got busy expected idle"); end
    model_depth = clamp_model(0);
    d = $urandom(); s = 3'($urandom_range(0, 7));
    in_data = d; in_sel = s; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle(); next_cycle();
    @(negedge UserCLK);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== model_out(d, s, model_depth)) begin errors++; $display("FAIL zero_data: got %h expected %h", out_data, model_out(d, s, model_depth)); end
    next_cycle();
  endtask

  task automatic test_reset_flush();
    logic [31:0] d;
    logic [2:0]  s;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom(); in_sel = 3'($urandom_range(0, 7)); in_valid = 1'b1;
      @(negedge UserCLK);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_accept_%0d: got %b expected 1", i, in_ready); end
      next_cycle();
    end
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL flush_out_data: got %h expected 0000", out_data); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL flush_cfg_busy: got %b expected 0", cfg_busy); end
    @(posedge UserCLK); #1;
    resetn = 1'b1; out_ready = 1'b0;
    model_depth = LOG2N;
    @(negedge UserCLK);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      @(negedge UserCLK);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale_c%0d: got %b expected 0", c, out_valid); end
    end
    next_cycle();
    d = $urandom(); s = 3'($urandom_range(0, 7));
    in_data = d; in_sel = s; in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle(); next_cycle();
    @(negedge UserCLK);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_new_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== model_out(d, s, model_depth)) begin errors++; $display("FAIL flush_new_data: got %h expected %h", out_data, model_out(d, s, model_depth)); end
    next_cycle();
  endtask

`ifdef MUX_TREE_PIPE_PARITY_EN
  task automatic test_parity();
    logic [31:0] d0, d1;
    d0 = $urandom(); d0[3:0] = 4'd7;
    d1 = $urandom(); d1[3:0] = 4'd6;
    out_ready = 1'b1; in_sel = 3'd0;
    in_data = d0; in_valid = 1'b1;
    next_cycle();
    in_data = d1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    @(negedge UserCLK);
    checks++; if (out_par !== model_par(model_out(d0, 3'd0, model_depth))) begin errors++; $display("FAIL par_seven: got %b expected %b", out_par, model_par(model_out(d0, 3'd0, model_depth))); end
    next_cycle();
    @(negedge UserCLK);
    checks++; if (out_par !== model_par(model_out(d1, 3'd0, model_depth))) begin errors++; $display("FAIL par_six: got %b expected %b", out_par, model_par(model_out(d1, 3'd0, model_depth))); end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_depth_one();
    test_back_to_back();
    test_cfg_inflight();
    test_cfg_zero();
    test_reset_flush();
`ifdef MUX_TREE_PIPE_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
